// File: rtl/fsk_tx_ctrl.sv
// -----------------------------------------------------------------------------
// fsk_tx_ctrl
//   Symbol sequencer for the FSK modulator. Each accepted byte is framed
//   UART-style (start bit, DATA_BITS data bits LSB first, optional even parity,
//   stop bit). Every symbol drives the frequency-select output `s` for exactly
//   CLKS_PER_BIT clocks. A one-entry holding register lets frames run back to
//   back with no idle gap.
//
//   Optional feature macro: FSK_PARITY_EN
//     defined   -> a PARITY symbol (XOR of the data bits) is sent before STOP
//     undefined -> DATA is followed directly by STOP
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   tx_data    in   byte to send, sampled on the handshake edge
//   tx_valid   in   tx_data valid
//   tx_ready   out  holding register empty
//   s          out  frequency select to the modulator (1 = freq1), registered
//   busy       out  FSM not in IDLE
//   bit_strobe out  1-cycle pulse in the first cycle of every symbol
//   frame_done out  1-cycle pulse in the last cycle of the STOP symbol
// -----------------------------------------------------------------------------
module fsk_tx_ctrl #(
  parameter int   CLKS_PER_BIT = 16,
  parameter int   DATA_BITS    = 8,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 s,
  output logic                 busy,
  output logic                 bit_strobe,
  output logic                 frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);
  // frame_done is registered, so it is raised one count before the last one.
  localparam logic [CW-1:0] CNT_PRELAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_LAST    = IW'(DATA_BITS - 1);

`ifdef FSK_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t               state_r;
  logic [CW-1:0]        baud_cnt_r;
  logic [IW-1:0]        bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] hold_reg_r;
  logic                 hold_full_r;
  logic                 hs_s;
  logic                 cnt_last_s;
  logic [DATA_BITS-1:0] load_data_s;
`ifdef FSK_PARITY_EN
  logic                 parity_r;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  assign tx_ready = !hold_full_r;
  assign busy     = (state_r != IDLE);

  // Handshake detect, symbol-end detect and the byte a new frame starts from.
  always_comb begin
    hs_s        = tx_valid && !hold_full_r;
    cnt_last_s  = (baud_cnt_r == CNT_LAST);
    load_data_s = hold_reg_r;
    // From IDLE with an empty holding register the incoming byte goes straight
    // to the shifter so the start bit follows the handshake edge directly.
    if (hold_full_r) begin
      load_data_s = hold_reg_r;
    end else begin
      load_data_s = tx_data;
    end
  end

  // Holding register, frame FSM, baud/bit counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      baud_cnt_r  <= '0;
      bit_idx_r   <= '0;
      shift_r     <= '0;
      hold_reg_r  <= '0;
      hold_full_r <= 1'b0;
      s           <= IDLE_LEVEL;
      bit_strobe  <= 1'b0;
      frame_done  <= 1'b0;
`ifdef FSK_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;

      // A consume later in this block overrides the set of hold_full_r.
      if (hs_s) begin
        hold_reg_r  <= tx_data;
        hold_full_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          s          <= IDLE_LEVEL;
          baud_cnt_r <= '0;
          if (hold_full_r || hs_s) begin
            shift_r     <= load_data_s;
`ifdef FSK_PARITY_EN
            parity_r    <= even_parity(load_data_s);
`endif
            hold_full_r <= 1'b0;
            state_r     <= START;
            s           <= ~IDLE_LEVEL;
            bit_strobe  <= 1'b1;
          end
        end

        START: begin
          if (cnt_last_s) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= '0;
            state_r    <= DATA;
            s          <= shift_r[0];
            bit_strobe <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1'b1);
          end
        end

        DATA: begin
          if (cnt_last_s) begin
            baud_cnt_r <= '0;
            bit_strobe <= 1'b1;
            if (bit_idx_r == IDX_LAST) begin
`ifdef FSK_PARITY_EN
              state_r <= PARITY;
              s       <= parity_r;
`else
              state_r <= STOP;
              s       <= IDLE_LEVEL;
`endif
            end else begin
              // Next symbol is the bit that becomes shift_r[0] after the shift.
              shift_r   <= shift_r >> 1;
              bit_idx_r <= bit_idx_r + IW'(1'b1);
              s         <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1'b1);
          end
        end

`ifdef FSK_PARITY_EN
        PARITY: begin
          if (cnt_last_s) begin
            baud_cnt_r <= '0;
            state_r    <= STOP;
            s          <= IDLE_LEVEL;
            bit_strobe <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1'b1);
          end
        end
`endif

        STOP: begin
          if (baud_cnt_r == CNT_PRELAST) begin
            frame_done <= 1'b1;
          end
          if (cnt_last_s) begin
            baud_cnt_r <= '0;
            if (hold_full_r) begin
              // Held byte starts immediately: no idle cycle between frames.
              shift_r     <= hold_reg_r;
`ifdef FSK_PARITY_EN
              parity_r    <= even_parity(hold_reg_r);
`endif
              hold_full_r <= 1'b0;
              state_r     <= START;
              s           <= ~IDLE_LEVEL;
              bit_strobe  <= 1'b1;
            end else begin
              state_r <= IDLE;
              s       <= IDLE_LEVEL;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1'b1);
          end
        end

        default: begin
          state_r     <= IDLE;
          baud_cnt_r  <= '0;
          s           <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_tx_ctrl.sv
module tb_fsk_tx_ctrl;

  localparam int CPB = 4;
`ifdef FSK_PARITY_EN
  localparam int NSYM = 11;
`else
  localparam int NSYM = 10;
`endif
  localparam int FLEN = NSYM * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       s;
  logic       busy;
  logic       bit_strobe;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  fsk_tx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .IDLE_LEVEL  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .s         (s),
    .busy      (busy),
    .bit_strobe(bit_strobe),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected level of `s` for symbol idx of a frame carrying byte b.
  function automatic logic exp_sym(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[3'(idx - 1)];
`ifdef FSK_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({s, busy, tx_ready, bit_strobe, frame_done} !== 5'b10100) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got s/busy/rdy/stb/done=%b want 10100", i,
                 {s, busy, tx_ready, bit_strobe, frame_done});
      end
    end
  endtask

  task automatic test_single_a5();
    logic [3:0] exp_v;
    int nstb = 0;
    @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL a5_ready got %b want 1", tx_ready);
    end
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < FLEN; k++) begin
      if (k > 0) @(negedge clk);
      nstb += int'(bit_strobe);
      exp_v = {exp_sym(8'hA5, k / CPB), (k % CPB) == 0, k == FLEN - 1, 1'b1};
      n_cmp++;
      if ({s, bit_strobe, frame_done, busy} !== exp_v) begin
        n_bad++;
        $display("FAIL a5_frame k=%0d got s/stb/done/busy=%b want %b", k,
                 {s, bit_strobe, frame_done, busy}, exp_v);
      end
    end
    n_cmp++;
    if (nstb != NSYM) begin
      n_bad++;
      $display("FAIL a5_strobes got %0d want %0d", nstb, NSYM);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, s} !== 2'b01) begin
      n_bad++;
      $display("FAIL a5_after got busy/s=%b want 01", {busy, s});
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_v;
    logic [7:0] b;
    int kk;
    @(negedge clk);
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2 * FLEN; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      b  = (k < FLEN) ? 8'h00 : 8'hFF;
      kk = k % FLEN;
      exp_v = {exp_sym(b, kk / CPB), (kk % CPB) == 0, kk == FLEN - 1, 1'b1,
               (k == 0) || (k >= FLEN)};
      n_cmp++;
      if ({s, bit_strobe, frame_done, busy, tx_ready} !== exp_v) begin
        n_bad++;
        $display("FAIL b2b k=%0d got s/stb/done/busy/rdy=%b want %b", k,
                 {s, bit_strobe, frame_done, busy, tx_ready}, exp_v);
      end
      if (k == 0) tx_data = 8'hFF;
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, s, tx_ready} !== 3'b011) begin
      n_bad++;
      $display("FAIL b2b_after got busy/s/rdy=%b want 011", {busy, s, tx_ready});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    tx_data = 8'h0F; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h3C;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (16) @(negedge clk);
    // Now in cycle 17 of the frame: data bit 3 of 0x0F.
    n_cmp++;
    if ({s, busy, tx_ready} !== 3'b110) begin
      n_bad++;
      $display("FAIL rstmid_before got s/busy/rdy=%b want 110", {s, busy, tx_ready});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({s, busy, tx_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL rstmid_after got s/busy/rdy=%b want 101", {s, busy, tx_ready});
    end
    for (int i = 0; i < 2 * FLEN; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({s, busy, bit_strobe} !== 3'b100) begin
        n_bad++;
        $display("FAIL rstmid_quiet cyc=%0d got s/busy/stb=%b want 100", i,
                 {s, busy, bit_strobe});
      end
    end
  endtask

  task automatic test_stop_handshake();
    logic [3:0] exp_v;
    @(negedge clk);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (FLEN - 1) @(negedge clk);
    n_cmp++;
    if ({frame_done, tx_ready, busy} !== 3'b111) begin
      n_bad++;
      $display("FAIL stophs_last got done/rdy/busy=%b want 111", {frame_done, tx_ready, busy});
    end
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n_cmp++;
    if ({busy, s, tx_ready, bit_strobe} !== 4'b0100) begin
      n_bad++;
      $display("FAIL stophs_gap got busy/s/rdy/stb=%b want 0100",
               {busy, s, tx_ready, bit_strobe});
    end
    for (int k = 0; k < FLEN; k++) begin
      @(negedge clk);
      exp_v = {exp_sym(8'h3C, k / CPB), (k % CPB) == 0, k == FLEN - 1, 1'b1};
      n_cmp++;
      if ({s, bit_strobe, frame_done, busy} !== exp_v) begin
        n_bad++;
        $display("FAIL stophs_frame k=%0d got s/stb/done/busy=%b want %b", k,
                 {s, bit_strobe, frame_done, busy}, exp_v);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, s, tx_ready} !== 3'b011) begin
      n_bad++;
      $display("FAIL stophs_after got busy/s/rdy=%b want 011", {busy, s, tx_ready});
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_reset_mid();
    test_stop_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
